m_wb_gpio: RTL and testbench

//  Wishbone classic slave GPIO block for midgetv boards. Replaces the ad-hoc LED latch and single-bit

---
 rtl/m_wb_gpio.sv | 129 ++++++++++++
 tb/tb_m_wb_gpio.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/m_wb_gpio.sv
// m_wb_gpio: Wishbone classic GPIO slave with NOUT outputs, NIN synchronised
// inputs and per-input change capture (EDGE, write-1-to-clear).
// Ports: CLK_I, RST_NI (sync, active-low), CYC_I/STB_I/WE_I/ADR_I/DAT_I/SEL_I in,
//        DAT_O/ACK_O out, gpio_in (async), gpio_out, irq (M_WB_GPIO_IRQ_EN only).
// Optional: define M_WB_GPIO_IRQ_EN for the MASK register and the irq output.
module m_wb_gpio #(
   parameter int              NOUT       = 4,
   parameter int              NIN        = 1,
   parameter int              SYNCSTAGES = 2,
   parameter logic [NOUT-1:0] OUTRESET   = '0
) (
   input  logic            CLK_I,
   input  logic            RST_NI,
   input  logic            CYC_I,
   input  logic            STB_I,
   input  logic            WE_I,
   input  logic [1:0]      ADR_I,
   input  logic [31:0]     DAT_I,
   input  logic [3:0]      SEL_I,
   output logic [31:0]     DAT_O,
   output logic            ACK_O,
   input  logic [NIN-1:0]  gpio_in,
   output logic [NOUT-1:0] gpio_out
`ifdef M_WB_GPIO_IRQ_EN
   ,
   output logic            irq
`endif
);

   logic                           req;
   logic                           wr;
   logic [31:0]                    wmask;
   logic [31:0]                    rdata;
   logic [NIN-1:0]                 s;
   logic [NIN-1:0]                 clr;
   logic [NOUT-1:0]                out_q, out_d;
   logic [SYNCSTAGES-1:0][NIN-1:0] sync_q, sync_d;
   logic [NIN-1:0]                 prev_q, prev_d;
   logic [NIN-1:0]                 edge_q, edge_d;
   logic                           ack_q, ack_d;
   logic [31:0]                    dat_q, dat_d;
`ifdef M_WB_GPIO_IRQ_EN
   logic [NIN-1:0]                 mask_q, mask_d;
   logic                           irq_q, irq_d;
`endif

   // Upper data / lane bits beyond NOUT and NIN are deliberately ignored.
   logic unused_ok;
   assign unused_ok = ^{DAT_I, wmask};

   assign s = sync_q[SYNCSTAGES-1];

   always_comb begin
      req    = CYC_I & STB_I & ~ack_q;
      wr     = req & WE_I;
      wmask  = {{8{SEL_I[3]}}, {8{SEL_I[2]}},
                {8{SEL_I[1]}}, {8{SEL_I[0]}}};
      sync_d = {sync_q[SYNCSTAGES-2:0], gpio_in};
      prev_d = s;

      out_d = out_q;
      if (wr && ADR_I == 2'd0)
         out_d = (out_q & ~wmask[NOUT-1:0])
               | (DAT_I[NOUT-1:0] & wmask[NOUT-1:0]);

      clr = '0;
      if (wr && ADR_I == 2'd2)
         clr = DAT_I[NIN-1:0] & wmask[NIN-1:0];
      // A fresh change in the same cycle as a clear must survive.
      edge_d = (edge_q & ~clr) | (s ^ prev_q);

`ifdef M_WB_GPIO_IRQ_EN
      mask_d = mask_q;
      if (wr && ADR_I == 2'd3)
         mask_d = (mask_q & ~wmask[NIN-1:0])
                | (DAT_I[NIN-1:0] & wmask[NIN-1:0]);
      irq_d = |(edge_q & mask_q);
`endif

      rdata = '0;
      unique case (ADR_I)
         2'd0: rdata[NOUT-1:0] = out_q;
         2'd1: rdata[NIN-1:0]  = s;
         2'd2: rdata[NIN-1:0]  = edge_q;
`ifdef M_WB_GPIO_IRQ_EN
         2'd3: rdata[NIN-1:0]  = mask_q;
`else
         2'd3: rdata           = '0;
`endif
      endcase

      ack_d = req;
      dat_d = req ? rdata : dat_q;
   end

   always_ff @(posedge CLK_I) begin
      // prev tracks s even in reset so release brings no false edge.
      prev_q <= prev_d;
      if (!RST_NI) begin
         out_q  <= OUTRESET;
         sync_q <= '0;
         edge_q <= '0;
         ack_q  <= 1'b0;
         dat_q  <= '0;
`ifdef M_WB_GPIO_IRQ_EN
         mask_q <= '0;
         irq_q  <= 1'b0;
`endif
      end else begin
         out_q  <= out_d;
         sync_q <= sync_d;
         edge_q <= edge_d;
         ack_q  <= ack_d;
         dat_q  <= dat_d;
`ifdef M_WB_GPIO_IRQ_EN
         mask_q <= mask_d;
         irq_q  <= irq_d;
`endif
      end
   end

   assign DAT_O    = dat_q;
   assign ACK_O    = ack_q;
   assign gpio_out = out_q;
`ifdef M_WB_GPIO_IRQ_EN
   assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_m_wb_gpio.sv
// tb_m_wb_gpio: directed bench for m_wb_gpio with a read-data scoreboard.
// Build with or without M_WB_GPIO_IRQ_EN.
module tb_m_wb_gpio;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [1:0]  adr;
   logic [31:0] dat_i, dat_o;
   logic [3:0]  sel;
   logic        ack;
   logic [1:0]  gin;
   logic [3:0]  gout;
`ifdef M_WB_GPIO_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   m_wb_gpio #(
      .NOUT(4), .NIN(2), .SYNCSTAGES(2), .OUTRESET(4'h5)
   ) dut (
      .CLK_I(clk), .RST_NI(rst_n), .CYC_I(cyc), .STB_I(stb),
      .WE_I(we), .ADR_I(adr), .DAT_I(dat_i), .SEL_I(sel),
      .DAT_O(dat_o), .ACK_O(ack), .gpio_in(gin), .gpio_out(gout)
`ifdef M_WB_GPIO_IRQ_EN
      , .irq(irq)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Caller must be at a negedge with ACK_O low before the next edge.
   task automatic access(input logic w, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp, input string tag);
      int n;
      logic [31:0] e;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      if (!w) exp_q.push_back(exp);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ack && n < 4);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check({tag, "_lat"}, 32'(n), 32'd1);
      if (!w) begin
         e = exp_q.pop_front();
         check(tag, dat_o, e);
      end
   endtask

   task automatic bus(input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp, input string tag);
      repeat (2) @(negedge clk);
      access(w, a, d, s, exp, tag);
   endtask

   // Change gin[0] before edge X; return at the negedge before X+dly.
   task automatic toggle(input logic v, input int dly);
      @(negedge clk);
      gin[0] = v;
      repeat (dly) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = '0; dat_i = '0; sel = '0; gin = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", 32'(gout), 32'h5);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_dat", dat_o, 32'h0);
`ifdef M_WB_GPIO_IRQ_EN
      check("rst_irq", 32'(irq), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      bus(0, 2, 0, 0, 32'h0, "edge_rst");
      bus(0, 0, 0, 0, 32'h5, "out_rst");
      bus(1, 0, 32'hFFFF_FFFA, 4'b0001, 0, "wr_out");
      check("gpio_out_a", 32'(gout), 32'hA);
      bus(0, 0, 0, 0, 32'hA, "rd_out_a");
      repeat (2) @(negedge clk);
      check("dat_hold", dat_o, 32'hA);
      bus(1, 0, 32'h0, 4'b0000, 0, "wr_nosel");
      bus(0, 0, 0, 0, 32'hA, "rd_nosel");
      bus(1, 0, 32'hFFFF_FFF3, 4'b1111, 0, "wr_full");
      bus(0, 0, 0, 0, 32'h3, "rd_full");
      bus(1, 0, 32'h0, 4'b0010, 0, "wr_lane1");
      bus(0, 0, 0, 0, 32'h3, "rd_lane1");

      toggle(1'b1, 1);
      access(0, 1, 0, 0, 32'h0, "in_early");
      repeat (4) @(negedge clk);
      bus(0, 1, 0, 0, 32'h1, "in_set");
      bus(0, 2, 0, 0, 32'h1, "edge_set");
      bus(1, 2, 32'h1, 4'b0001, 0, "w1c");
      bus(0, 2, 0, 0, 32'h0, "edge_clr");

      toggle(1'b0, 2);
      access(0, 1, 0, 0, 32'h0, "in_exact");
      repeat (4) @(negedge clk);
      bus(1, 2, 32'hFF, 4'b1111, 0, "w1c_all");
      bus(0, 2, 0, 0, 32'h0, "edge_clr2");

      toggle(1'b1, 2);
      access(0, 2, 0, 0, 32'h0, "edge_early");
      bus(0, 2, 0, 0, 32'h1, "edge_late");
      bus(1, 2, 32'h1, 4'b0001, 0, "w1c2");
      toggle(1'b0, 3);
      access(0, 2, 0, 0, 32'h1, "edge_exact");

      toggle(1'b1, 2);
      access(1, 2, 32'h1, 4'b0001, 0, "w1c_race");
      bus(0, 2, 0, 0, 32'h1, "set_wins");

      @(negedge clk);
      gin[1] = 1'b1;
      repeat (4) @(negedge clk);
      bus(0, 1, 0, 0, 32'h3, "in_both");
      bus(0, 2, 0, 0, 32'h3, "edge_both");
      bus(1, 2, 32'h2, 4'b0001, 0, "w1c_bit1");
      bus(0, 2, 0, 0, 32'h1, "edge_bit0");

      bus(1, 1, 32'h0, 4'b1111, 0, "wr_in");
      bus(0, 1, 0, 0, 32'h3, "in_ro");
      bus(0, 0, 0, 0, 32'h3, "out_keep");

`ifdef M_WB_GPIO_IRQ_EN
      repeat (2) @(negedge clk);
      check("irq_masked", 32'(irq), 32'h0);
      bus(1, 3, 32'hFFFF_FFFF, 4'b1111, 0, "wr_mask");
      bus(0, 3, 0, 0, 32'h3, "rd_mask");
      repeat (2) @(negedge clk);
      check("irq_on", 32'(irq), 32'h1);
      @(negedge clk);
      access(1, 2, 32'h3, 4'b0001, 0, "w1c_irq");
      check("irq_hold", 32'(irq), 32'h1);
      @(posedge clk); #1;
      check("irq_clr", 32'(irq), 32'h0);
`else
      bus(1, 3, 32'hFFFF_FFFF, 4'b1111, 0, "wr_adr3");
      bus(0, 3, 0, 0, 32'h0, "rd_adr3");
`endif

      repeat (2) @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("ack_pat%0d", i), 32'(ack), 32'(i % 2));
         @(negedge clk);
      end
      cyc = 1'b0; stb = 1'b0;

      gin = '0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0;
      dat_i = 32'hFFFF_FFFF; sel = 4'b1111;
      @(posedge clk); #1;
      check("rst_req_ack", 32'(ack), 32'h0);
      check("rst_req_out", 32'(gout), 32'h5);
      check("rst_req_dat", dat_o, 32'h0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus(0, 2, 0, 0, 32'h0, "edge_rst2");
      bus(0, 0, 0, 0, 32'h5, "out_rst2");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
